// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
`ifndef RF_WB_ARBITER_PKG_SV
`define RF_WB_ARBITER_PKG_SV

// Packed-vector slice of element i, each w bits wide.
`define RF_SLICE(i, w) (i)*(w) +: (w)

package rf_wb_arbiter_pkg;

  localparam int DEF_NUM_FU   = 8;
  localparam int DEF_NUM_PORT = 2;
  localparam int DEF_NUM_REG  = 16;
  localparam int DEF_REG_BIT  = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/rf_wb_arbiter_find.sv
// Round-robin first-set finder: scans req_mask from rr_ptr upward, wrapping
// at NUM_REQ, and reports the first set bit as one-hot and as an index.
module rr_find_first #(
  parameter int NUM_REQ    = 8,
  parameter int REQ_ID_BIT = 3
) (
  input  logic [NUM_REQ-1:0]    req_mask,
  input  logic [REQ_ID_BIT-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]    pick,
  output logic [REQ_ID_BIT-1:0] idx,
  output logic                  found
);

  // Wrapping scan; the wrap is a compare-and-subtract so NUM_REQ need not be a power of 2.
  always_comb begin
    int cand;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = int'(rr_ptr) + j;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_mask[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        idx         = REQ_ID_BIT'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing NUM_PORT registered RF write slots among
// NUM_REQ writeback requesters, serializing same-cycle writes to one reg id.
// Handshake: a transfer happens on an edge where valid && ready are both high;
// valid must not depend on ready, ready may depend on valid.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_FU,
  parameter int NUM_PORT   = DEF_NUM_PORT,
  parameter int NUM_REG    = DEF_NUM_REG,
  parameter int REG_BIT    = DEF_REG_BIT,
  parameter int REG_ID_BIT = clog2_safe(NUM_REG),
  parameter int REQ_ID_BIT = clog2_safe(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ*REG_ID_BIT-1:0]  req_reg_id,
  input  logic [NUM_REQ*REG_BIT-1:0]     req_data,
  output logic [NUM_PORT-1:0]            wr_vld,
  input  logic [NUM_PORT-1:0]            wr_rdy,
  output logic [NUM_PORT*REG_ID_BIT-1:0] wr_addr,
  output logic [NUM_PORT*REG_BIT-1:0]    wr_data,
  output logic [NUM_PORT*REQ_ID_BIT-1:0] wr_src,
  output logic                           busy
);

  logic [NUM_PORT-1:0]            wr_vld_q,  wr_vld_d;
  logic [NUM_PORT*REG_ID_BIT-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_PORT*REG_BIT-1:0]    wr_data_q, wr_data_d;
  logic [NUM_PORT*REQ_ID_BIT-1:0] wr_src_q,  wr_src_d;
  logic [REQ_ID_BIT-1:0]          rr_ptr_q,  rr_ptr_d;

  logic [NUM_PORT-1:0][NUM_REQ-1:0]    stage_pick;
  logic [NUM_PORT-1:0][REQ_ID_BIT-1:0] stage_idx;
  logic [NUM_PORT-1:0]                 stage_found;

  // Requesters sharing the reg id of requester sel (sel itself included).
  function automatic logic [NUM_REQ-1:0] same_id(
    input logic [NUM_REQ*REG_ID_BIT-1:0] ids,
    input logic [REQ_ID_BIT-1:0]         sel
  );
    logic [NUM_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m[i] = (ids[`RF_SLICE(i, REG_ID_BIT)] == ids[`RF_SLICE(sel, REG_ID_BIT)]);
    end
    return m;
  endfunction

  // Finder chain: each stage drops the previous pick and every requester
  // targeting the same reg id, so picks are unique-id and in scan order.
  for (genvar k = 0; k < NUM_PORT; k++) begin : g_stage
    logic [NUM_REQ-1:0] mask_in;
    logic [NUM_REQ-1:0] mask_next;
    if (k == 0) begin : g_first
      assign mask_in = req_vld;
    end else begin : g_rest
      assign mask_in = g_stage[k-1].mask_next;
    end
    rr_find_first #(
      .NUM_REQ    (NUM_REQ),
      .REQ_ID_BIT (REQ_ID_BIT)
    ) u_find (
      .req_mask (mask_in),
      .rr_ptr   (rr_ptr_q),
      .pick     (stage_pick[k]),
      .idx      (stage_idx[k]),
      .found    (stage_found[k])
    );
    assign mask_next = stage_found[k] ?
                       (mask_in & ~same_id(req_reg_id, stage_idx[k])) : '0;
  end

  // Free-slot compaction, grant generation, slot drain/refill and pointer advance.
  always_comb begin
    logic [NUM_PORT-1:0]   free;
    logic [NUM_PORT-1:0]   grant_vld;
    logic [REQ_ID_BIT-1:0] last_idx;
    logic [REQ_ID_BIT-1:0] src;
    logic                  any_grant;
    int                    free_cnt;
    int                    rank;
    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    rr_ptr_d  = rr_ptr_q;
    req_rdy   = '0;
    free      = '0;
    grant_vld = '0;
    last_idx  = '0;
    src       = '0;
    any_grant = 1'b0;
    free_cnt  = 0;
    rank      = 0;
    for (int p = 0; p < NUM_PORT; p++) begin
      free[p] = !wr_vld_q[p] || wr_rdy[p];
      if (free[p]) free_cnt = free_cnt + 1;
    end
    for (int k = 0; k < NUM_PORT; k++) begin
      grant_vld[k] = stage_found[k] && (k < free_cnt);
      if (grant_vld[k]) begin
        req_rdy   = req_rdy | stage_pick[k];
        last_idx  = stage_idx[k];
        any_grant = 1'b1;
      end
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      if (wr_vld_q[p] && wr_rdy[p]) wr_vld_d[p] = 1'b0;
      if (free[p]) begin
        if (grant_vld[rank]) begin
          src                                 = stage_idx[rank];
          wr_vld_d[p]                         = 1'b1;
          wr_addr_d[`RF_SLICE(p, REG_ID_BIT)] = req_reg_id[`RF_SLICE(src, REG_ID_BIT)];
          wr_data_d[`RF_SLICE(p, REG_BIT)]    = req_data[`RF_SLICE(src, REG_BIT)];
          wr_src_d[`RF_SLICE(p, REQ_ID_BIT)]  = src;
        end
        rank = rank + 1;
      end
    end
    if (any_grant) begin
      rr_ptr_d = (last_idx == REQ_ID_BIT'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Slot and pointer registers; reset discards every slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign wr_vld  = wr_vld_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;
  assign busy    = |wr_vld_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: an 8-requester instance for the main
// scenarios and a 5-requester instance for the non-power-of-2 wrap.
module tb_rf_wb_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // 8 requesters, 2 ports
  logic [7:0]   req_vld8,  req_rdy8;
  logic [31:0]  req_reg_id8;
  logic [127:0] req_data8;
  logic [1:0]   wr_vld8, wr_rdy8;
  logic [7:0]   wr_addr8;
  logic [31:0]  wr_data8;
  logic [5:0]   wr_src8;
  logic         busy8;

  // 5 requesters, 2 ports
  logic [4:0]   req_vld5,  req_rdy5;
  logic [19:0]  req_reg_id5;
  logic [79:0]  req_data5;
  logic [1:0]   wr_vld5, wr_rdy5;
  logic [7:0]   wr_addr5;
  logic [31:0]  wr_data5;
  logic [5:0]   wr_src5;
  logic         busy5;

  rf_wb_arbiter #(.NUM_REQ(8), .NUM_PORT(2), .NUM_REG(16), .REG_BIT(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld8), .req_rdy(req_rdy8),
    .req_reg_id(req_reg_id8), .req_data(req_data8), .wr_vld(wr_vld8),
    .wr_rdy(wr_rdy8), .wr_addr(wr_addr8), .wr_data(wr_data8),
    .wr_src(wr_src8), .busy(busy8)
  );

  rf_wb_arbiter #(.NUM_REQ(5), .NUM_PORT(2), .NUM_REG(16), .REG_BIT(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld5), .req_rdy(req_rdy5),
    .req_reg_id(req_reg_id5), .req_data(req_data5), .wr_vld(wr_vld5),
    .wr_rdy(wr_rdy5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .wr_src(wr_src5), .busy(busy5)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req8(input int i, input logic [3:0] id, input logic [15:0] d);
    req_reg_id8[i*4 +: 4]  = id;
    req_data8[i*16 +: 16]  = d;
  endtask

  task automatic set_req5(input int i, input logic [3:0] id, input logic [15:0] d);
    req_reg_id5[i*4 +: 4]  = id;
    req_data5[i*16 +: 16]  = d;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_vld8    = '0;
    req_reg_id8 = '0;
    req_data8   = '0;
    wr_rdy8     = '0;
    req_vld5    = '0;
    req_reg_id5 = '0;
    req_data5   = '0;
    wr_rdy5     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req_vld8 = '0;
    wr_rdy8  = '0;
    #2;
    total++; if (wr_vld8 !== 2'b00) begin bad++; $display("FAIL reset_wr_vld got=%b exp=00", wr_vld8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (dut8.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut8.rr_ptr_q); end
    total++; if ({wr_addr8, wr_data8, wr_src8} !== 46'd0) begin bad++; $display("FAIL reset_slots got=%h exp=0", {wr_addr8, wr_data8, wr_src8}); end
    total++; if (req_rdy8 !== 8'h00) begin bad++; $display("FAIL reset_req_rdy got=%h exp=00", req_rdy8); end
  endtask

  task automatic test_single();
    do_reset();
    set_req8(2, 4'd5, 16'hBEEF);
    req_vld8 = 8'b0000_0100;
    wr_rdy8  = 2'b11;
    #1;
    total++; if (req_rdy8 !== 8'h04) begin bad++; $display("FAIL single_rdy got=%h exp=04", req_rdy8); end
    step();
    req_vld8 = '0;
    total++; if (wr_vld8 !== 2'b01) begin bad++; $display("FAIL single_wr_vld got=%b exp=01", wr_vld8); end
    total++; if (wr_addr8[3:0] !== 4'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", wr_addr8[3:0]); end
    total++; if (wr_data8[15:0] !== 16'hBEEF) begin bad++; $display("FAIL single_data got=%h exp=BEEF", wr_data8[15:0]); end
    total++; if (wr_src8[2:0] !== 3'd2) begin bad++; $display("FAIL single_src got=%0d exp=2", wr_src8[2:0]); end
    total++; if (dut8.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL single_rr_ptr got=%0d exp=3", dut8.rr_ptr_q); end
    step();
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL single_drain_busy got=%b exp=0", busy8); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rdy;
    int         first;
    int         cnt [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req8(i, 4'(i), 16'h1000 + 16'(i));
      cnt[i] = 0;
    end
    req_vld8 = 8'hFF;
    wr_rdy8  = 2'b11;
    for (int c = 0; c < 5; c++) begin
      exp_rdy = 8'h03 << (2 * (c % 4));
      first   = (2 * c) % 8;
      #1;
      total++; if (req_rdy8 !== exp_rdy) begin bad++; $display("FAIL rr_rdy_c%0d got=%h exp=%h", c, req_rdy8, exp_rdy); end
      if (c < 4) begin
        for (int i = 0; i < 8; i++) if (req_rdy8[i]) cnt[i]++;
      end
      step();
      total++; if (wr_src8 !== {3'(first + 1), 3'(first)}) begin bad++; $display("FAIL rr_src_c%0d got=%h exp=%h", c, wr_src8, {3'(first + 1), 3'(first)}); end
    end
    for (int i = 0; i < 8; i++) begin
      total++; if (cnt[i] != 1) begin bad++; $display("FAIL rr_fair_req%0d got=%0d exp=1", i, cnt[i]); end
    end
    req_vld8 = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) set_req8(i, 4'(i), 16'h1000 + 16'(i));
    req_vld8 = 8'hFF;
    wr_rdy8  = 2'b11;
    step();
    wr_rdy8 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_rdy8 !== 8'h00) begin bad++; $display("FAIL bp_rdy_c%0d got=%h exp=00", c, req_rdy8); end
      total++; if (wr_vld8 !== 2'b11 || busy8 !== 1'b1) begin bad++; $display("FAIL bp_vld_c%0d got=%b/%b exp=11/1", c, wr_vld8, busy8); end
      total++; if (wr_src8 !== {3'd1, 3'd0} || wr_data8 !== {16'h1001, 16'h1000}) begin bad++; $display("FAIL bp_hold_c%0d got=%h/%h exp=08/10011000", c, wr_src8, wr_data8); end
      step();
    end
    total++; if (dut8.rr_ptr_q !== 3'd2) begin bad++; $display("FAIL bp_rr_hold got=%0d exp=2", dut8.rr_ptr_q); end
    wr_rdy8 = 2'b10;
    #1;
    total++; if (req_rdy8 !== 8'h04) begin bad++; $display("FAIL bp_one_grant got=%h exp=04", req_rdy8); end
    step();
    wr_rdy8 = 2'b00;
    total++; if (wr_src8 !== {3'd2, 3'd0} || wr_vld8 !== 2'b11) begin bad++; $display("FAIL bp_slot1_refill got=%h/%b exp=10/11", wr_src8, wr_vld8); end
    total++; if (wr_addr8 !== {4'd2, 4'd0}) begin bad++; $display("FAIL bp_slot1_addr got=%h exp=20", wr_addr8); end
    total++; if (dut8.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL bp_rr_next got=%0d exp=3", dut8.rr_ptr_q); end
    req_vld8 = '0;
    wr_rdy8  = 2'b11;
    step();
    total++; if (busy8 !== 1'b0 || wr_vld8 !== 2'b00) begin bad++; $display("FAIL bp_drain got=%b/%b exp=0/00", busy8, wr_vld8); end
  endtask

  task automatic test_duplicate();
    do_reset();
    set_req8(2, 4'd0, 16'h2222);
    req_vld8 = 8'h04;
    wr_rdy8  = 2'b11;
    step();
    set_req8(3, 4'd7, 16'h3333);
    set_req8(4, 4'd7, 16'h4444);
    req_vld8 = 8'h18;
    #1;
    total++; if (req_rdy8 !== 8'h08) begin bad++; $display("FAIL dup_first_rdy got=%h exp=08", req_rdy8); end
    step();
    req_vld8 = 8'h10;
    #1;
    total++; if (req_rdy8 !== 8'h10) begin bad++; $display("FAIL dup_retry_rdy got=%h exp=10", req_rdy8); end
    total++; if (wr_vld8 !== 2'b01 || wr_src8[2:0] !== 3'd3 || wr_data8[15:0] !== 16'h3333) begin bad++; $display("FAIL dup_slot_first got=%b/%0d/%h exp=01/3/3333", wr_vld8, wr_src8[2:0], wr_data8[15:0]); end
    total++; if (dut8.rr_ptr_q !== 3'd4) begin bad++; $display("FAIL dup_rr_first got=%0d exp=4", dut8.rr_ptr_q); end
    step();
    req_vld8 = '0;
    total++; if (wr_vld8 !== 2'b01 || wr_src8[2:0] !== 3'd4 || wr_data8[15:0] !== 16'h4444 || wr_addr8[3:0] !== 4'd7) begin bad++; $display("FAIL dup_slot_second got=%b/%0d/%h/%0d exp=01/4/4444/7", wr_vld8, wr_src8[2:0], wr_data8[15:0], wr_addr8[3:0]); end
    total++; if (dut8.rr_ptr_q !== 3'd5) begin bad++; $display("FAIL dup_rr_second got=%0d exp=5", dut8.rr_ptr_q); end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    set_req5(3, 4'd1, 16'h3030);
    req_vld5 = 5'b01000;
    wr_rdy5  = 2'b11;
    step();
    total++; if (dut5.rr_ptr_q !== 3'd4) begin bad++; $display("FAIL wrap_setup_rr got=%0d exp=4", dut5.rr_ptr_q); end
    set_req5(4, 4'd2, 16'hA4A4);
    set_req5(0, 4'd9, 16'hA0A0);
    req_vld5 = 5'b10001;
    #1;
    total++; if (req_rdy5 !== 5'b10001) begin bad++; $display("FAIL wrap_rdy got=%b exp=10001", req_rdy5); end
    step();
    req_vld5 = '0;
    total++; if (wr_vld5 !== 2'b11 || wr_src5 !== {3'd0, 3'd4}) begin bad++; $display("FAIL wrap_src got=%b/%h exp=11/04", wr_vld5, wr_src5); end
    total++; if (wr_data5 !== {16'hA0A0, 16'hA4A4} || wr_addr5 !== {4'd9, 4'd2}) begin bad++; $display("FAIL wrap_payload got=%h/%h exp=A0A0A4A4/92", wr_data5, wr_addr5); end
    total++; if (dut5.rr_ptr_q !== 3'd1) begin bad++; $display("FAIL wrap_rr got=%0d exp=1", dut5.rr_ptr_q); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req8(0, 4'd1, 16'h0101);
    set_req8(1, 4'd2, 16'h0202);
    req_vld8 = 8'h03;
    wr_rdy8  = 2'b00;
    step();
    req_vld8 = '0;
    total++; if (wr_vld8 !== 2'b11 || busy8 !== 1'b1) begin bad++; $display("FAIL ar_fill got=%b/%b exp=11/1", wr_vld8, busy8); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wr_vld8 !== 2'b00 || busy8 !== 1'b0) begin bad++; $display("FAIL ar_clear got=%b/%b exp=00/0", wr_vld8, busy8); end
    total++; if (dut8.rr_ptr_q !== 3'd0 || wr_src8 !== 6'd0) begin bad++; $display("FAIL ar_ptr got=%0d/%h exp=0/00", dut8.rr_ptr_q, wr_src8); end
    #1;
    rst_n = 1'b1;
    step();
    set_req8(6, 4'd3, 16'hC0DE);
    req_vld8 = 8'h40;
    wr_rdy8  = 2'b11;
    #1;
    total++; if (req_rdy8 !== 8'h40) begin bad++; $display("FAIL ar_post_rdy got=%h exp=40", req_rdy8); end
    step();
    req_vld8 = '0;
    total++; if (wr_vld8 !== 2'b01 || wr_src8[2:0] !== 3'd6 || wr_data8[15:0] !== 16'hC0DE) begin bad++; $display("FAIL ar_post_slot got=%b/%0d/%h exp=01/6/C0DE", wr_vld8, wr_src8[2:0], wr_data8[15:0]); end
    total++; if (dut8.rr_ptr_q !== 3'd7) begin bad++; $display("FAIL ar_post_rr got=%0d exp=7", dut8.rr_ptr_q); end
    step();
  endtask

  // Test sequence and report
  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    req_vld8    = '0;
    req_reg_id8 = '0;
    req_data8   = '0;
    wr_rdy8     = '0;
    req_vld5    = '0;
    req_reg_id5 = '0;
    req_data5   = '0;
    wr_rdy5     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_duplicate();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
